vert_ucode_quicksort_bank_sched: RTL and testbench

//  Bank scheduler for the microcoded quicksort engine. Owns the per-bank context
//  (status, element count, error) for BANK_N sort banks. Moves each bank round-robin

---
 rtl/vert_ucode_quicksort_pkg.sv | 35 +++
 rtl/vert_ucode_quicksort_bank_ctxt.sv | 41 ++++
 rtl/vert_ucode_quicksort_bank_sched.sv | 161 ++++++++++++++++
 tb/tb_vert_ucode_quicksort_bank_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vert_ucode_quicksort_pkg.sv
// Shared types and sizing for the quicksort bank scheduler.
package vert_ucode_quicksort_pkg;
    localparam int N      = 16;
    localparam int W      = 32;
    localparam int BANK_N = 2;
    localparam int BANK_W = (BANK_N > 1) ? $clog2(BANK_N) : 1;

    typedef logic [BANK_W-1:0]        bank_n_t;
    typedef logic [$clog2(N+1)-1:0]   n_t;
    typedef logic [$clog2(N)-1:0]     addr_t;
    typedef logic [W-1:0]             w_t;

    typedef enum logic [2:0] {
        BS_IDLE      = 3'd0,
        BS_LOADING   = 3'd1,
        BS_READY     = 3'd2,
        BS_SORTING   = 3'd3,
        BS_SORTED    = 3'd4,
        BS_UNLOADING = 3'd5
    } bank_status_t;

    typedef struct packed {
        bank_status_t status;
        n_t           n;
        logic         error;
    } bank_state_t;

    typedef enum logic { ENQ_IDLE, ENQ_LOAD } enqueue_fsm_t;
    typedef enum logic { DEQ_IDLE, DEQ_EMIT } dequeue_fsm_t;

    // Round-robin successor; also correct for non-power-of-two bank counts.
    function automatic bank_n_t bank_inc(input bank_n_t b);
        return (int'(b) == BANK_N - 1) ? '0 : bank_n_t'(b + 1'b1);
    endfunction
endpackage

// File: rtl/vert_ucode_quicksort_bank_ctxt.sv
// Per-bank context: status, element count and sticky error for one sort bank.
module vert_ucode_quicksort_bank_ctxt
    import vert_ucode_quicksort_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        commit,
    input  logic        start,
    input  logic        done,
    input  logic        done_error,
    input  logic        unload_start,
    input  logic        unload_end,
    output bank_state_t state
);
    // Lifecycle events; the top only raises events legal for the current status,
    // so at most one group fires for this bank in any cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state.status <= BS_IDLE;
            state.n      <= '0;
            state.error  <= 1'b0;
        end else begin
            if (load) begin
                state.n      <= n_t'(state.n + 1'b1);
                state.status <= commit ? BS_READY : BS_LOADING;
            end
            if (start) state.status <= BS_SORTING;
            if (done) begin
                state.status <= BS_SORTED;
                state.error  <= state.error | done_error;
            end
            if (unload_start) state.status <= BS_UNLOADING;
            if (unload_end) begin
                state.status <= BS_IDLE;
                state.n      <= '0;
                state.error  <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/vert_ucode_quicksort_bank_sched.sv
// Bank scheduler: round-robin enqueue, sort dispatch and dequeue over BANK_N banks.
module vert_ucode_quicksort_bank_sched
    import vert_ucode_quicksort_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic [W-1:0]          in_w,
    input  logic                  in_commit,
    output logic                  in_rdy,
    output logic [BANK_N-1:0]     bank_wr_en,
    output addr_t                 bank_wr_addr,
    output logic [W-1:0]          bank_wr_data,
    output logic [BANK_N-1:0]     bank_rd_en,
    output addr_t                 bank_rd_addr,
    input  logic [BANK_N*W-1:0]   bank_rd_data,
    output logic                  sort_start,
    output bank_n_t               sort_bank,
    output n_t                    sort_n,
    input  logic                  sort_done,
    input  logic                  sort_error,
    output logic                  out_vld,
    output logic [W-1:0]          out_w,
    output logic                  out_last,
    output logic                  out_error,
    output logic [BANK_N*3-1:0]   bank_status
);
    bank_state_t        bank_st [BANK_N];
    bank_n_t            enq_ptr, sort_ptr, deq_ptr, out_bank;
    enqueue_fsm_t       enq_state, enq_next;
    dequeue_fsm_t       deq_state, deq_next;
    logic               accept, enq_commit, dispatch, finish, rd_last;
    logic [BANK_N-1:0]  ev_ustart, ev_uend;
    addr_t              rd_cnt;

    for (genvar b = 0; b < BANK_N; b++) begin : g_bank
        vert_ucode_quicksort_bank_ctxt u_ctxt (
            .clk          (clk),
            .rst          (rst),
            .load         (accept && (enq_ptr == bank_n_t'(b))),
            .commit       (enq_commit),
            .start        (dispatch && (sort_ptr == bank_n_t'(b))),
            .done         (finish && (sort_ptr == bank_n_t'(b))),
            .done_error   (sort_error),
            .unload_start (ev_ustart[b]),
            .unload_end   (ev_uend[b]),
            .state        (bank_st[b])
        );
        assign bank_status[b*3 +: 3] = bank_st[b].status;
    end

    // Enqueue FSM state register
    always_ff @(posedge clk) begin
        if (rst) enq_state <= ENQ_IDLE;
        else     enq_state <= enq_next;
    end

    // Enqueue next state: LOAD while a set is partially written
    always_comb begin
        enq_next = enq_state;
        case (enq_state)
            ENQ_IDLE: if (accept && !enq_commit) enq_next = ENQ_LOAD;
            ENQ_LOAD: if (accept && enq_commit)  enq_next = ENQ_IDLE;
            default:  enq_next = ENQ_IDLE;
        endcase
    end

    // Enqueue outputs: ready and write port from registered bank state only
    always_comb begin
        in_rdy       = (bank_st[enq_ptr].status == BS_IDLE) ||
                       (bank_st[enq_ptr].status == BS_LOADING);
        accept       = in_vld && in_rdy && !rst;
        enq_commit   = in_commit || (bank_st[enq_ptr].n == n_t'(N - 1));
        bank_wr_en   = '0;
        bank_wr_addr = '0;
        bank_wr_data = '0;
        if (accept) begin
            bank_wr_en[enq_ptr] = 1'b1;
            bank_wr_addr        = addr_t'(bank_st[enq_ptr].n);
            bank_wr_data        = in_w;
        end
    end

    // The sort_ptr bank is SORTING exactly while the engine is busy, so its
    // status alone gates dispatch and filters spurious completions.
    assign dispatch = (bank_st[sort_ptr].status == BS_READY);
    assign finish   = sort_done && (bank_st[sort_ptr].status == BS_SORTING);

    // Enqueue/sort pointers and the registered engine interface
    always_ff @(posedge clk) begin
        if (rst) begin
            enq_ptr    <= '0;
            sort_ptr   <= '0;
            sort_start <= 1'b0;
            sort_bank  <= '0;
            sort_n     <= '0;
        end else begin
            if (accept && enq_commit) enq_ptr <= bank_inc(enq_ptr);
            sort_start <= dispatch;
            if (dispatch) begin
                sort_bank <= sort_ptr;
                sort_n    <= bank_st[sort_ptr].n;
            end
            if (finish) sort_ptr <= bank_inc(sort_ptr);
        end
    end

    assign rd_last = (n_t'(rd_cnt) == n_t'(bank_st[deq_ptr].n - 1'b1));

    // Dequeue FSM state register
    always_ff @(posedge clk) begin
        if (rst) deq_state <= DEQ_IDLE;
        else     deq_state <= deq_next;
    end

    // Dequeue next state: EMIT from a SORTED bank until its last address is read
    always_comb begin
        deq_next = deq_state;
        case (deq_state)
            DEQ_IDLE: if (bank_st[deq_ptr].status == BS_SORTED) deq_next = DEQ_EMIT;
            DEQ_EMIT: if (rd_last) deq_next = DEQ_IDLE;
            default:  deq_next = DEQ_IDLE;
        endcase
    end

    // Dequeue outputs: read port and unload events for the deq_ptr bank
    always_comb begin
        ev_ustart    = '0;
        ev_uend      = '0;
        bank_rd_en   = '0;
        bank_rd_addr = '0;
        if (deq_state == DEQ_IDLE) begin
            if (bank_st[deq_ptr].status == BS_SORTED) ev_ustart[deq_ptr] = 1'b1;
        end else begin
            bank_rd_en[deq_ptr] = 1'b1;
            bank_rd_addr        = rd_cnt;
            if (rd_last) ev_uend[deq_ptr] = 1'b1;
        end
    end

    // Read counter, dequeue pointer and the one-cycle output alignment stage
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt    <= '0;
            deq_ptr   <= '0;
            out_bank  <= '0;
            out_vld   <= 1'b0;
            out_last  <= 1'b0;
            out_error <= 1'b0;
        end else begin
            out_vld   <= (deq_state == DEQ_EMIT);
            out_last  <= (deq_state == DEQ_EMIT) && rd_last;
            out_error <= (deq_state == DEQ_EMIT) && bank_st[deq_ptr].error;
            out_bank  <= deq_ptr;
            rd_cnt    <= (deq_state == DEQ_EMIT) ? addr_t'(rd_cnt + 1'b1) : '0;
            if ((deq_state == DEQ_EMIT) && rd_last) deq_ptr <= bank_inc(deq_ptr);
        end
    end

    assign out_w = out_vld ? bank_rd_data[int'(out_bank)*W +: W] : '0;
endmodule

// File: tb/tb_vert_ucode_quicksort_bank_sched.sv
// Self-checking bench: bank memory and sort-engine models plus an output scoreboard.
module tb_vert_ucode_quicksort_bank_sched;
    localparam int N = 16, W = 32, BN = 2;
    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_READY = 3'd2,
                           S_SORTING = 3'd3, S_SORTED = 3'd4;

    logic clk = 1'b0, rst = 1'b1;
    logic in_vld = 1'b0, in_commit = 1'b0, in_rdy;
    logic [W-1:0] in_w = '0;
    logic [BN-1:0] bank_wr_en, bank_rd_en;
    logic [3:0] bank_wr_addr, bank_rd_addr;
    logic [W-1:0] bank_wr_data, out_w;
    logic [BN*W-1:0] bank_rd_data;
    logic sort_start, sort_done = 1'b0, sort_error = 1'b0;
    logic [0:0] sort_bank;
    logic [4:0] sort_n;
    logic out_vld, out_last, out_error;
    logic [BN*3-1:0] bank_status;

    always #5 clk = ~clk;

    vert_ucode_quicksort_bank_sched dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_w(in_w), .in_commit(in_commit),
        .in_rdy(in_rdy), .bank_wr_en(bank_wr_en), .bank_wr_addr(bank_wr_addr),
        .bank_wr_data(bank_wr_data), .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr),
        .bank_rd_data(bank_rd_data), .sort_start(sort_start), .sort_bank(sort_bank),
        .sort_n(sort_n), .sort_done(sort_done), .sort_error(sort_error),
        .out_vld(out_vld), .out_w(out_w), .out_last(out_last), .out_error(out_error),
        .bank_status(bank_status)
    );

    // Bank RAMs with one-cycle read latency; the engine model leaves data in place
    logic [W-1:0] mem [BN][N];
    logic [W-1:0] rdq [BN];
    always @(posedge clk) begin
        for (int b = 0; b < BN; b++) begin
            if (bank_wr_en[b]) mem[b][bank_wr_addr] <= bank_wr_data;
            if (bank_rd_en[b]) rdq[b] <= mem[b][bank_rd_addr];
        end
    end
    assign bank_rd_data = {rdq[1], rdq[0]};

    typedef struct { logic [W-1:0] w; logic last; logic err; } beat_t;
    typedef struct { int bank; int n; } start_t;
    beat_t  exp_q[$], obs_q[$];
    start_t start_q[$];
    logic [W-1:0] pend [BN][$];
    beat_t  mon_b;
    start_t mon_s;

    // Capture output beats and engine start pulses as they happen
    always @(negedge clk) begin
        if (out_vld === 1'b1) begin
            mon_b.w = out_w; mon_b.last = out_last; mon_b.err = out_error;
            obs_q.push_back(mon_b);
        end
        if (sort_start === 1'b1) begin
            mon_s.bank = int'(sort_bank); mon_s.n = int'(sort_n);
            start_q.push_back(mon_s);
        end
    end

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic enq(input logic [W-1:0] w, input bit cm, input bit exp_rdy,
                       input int eb, input int ea);
        in_vld = 1'b1; in_w = w; in_commit = cm;
        #1;
        chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
        if (exp_rdy) begin
            chk("wr_en", 64'(bank_wr_en), 64'(1) << eb);
            chk("wr_addr", 64'(bank_wr_addr), 64'(ea));
            chk("wr_data", 64'(bank_wr_data), 64'(w));
            pend[eb].push_back(w);
        end else begin
            chk("wr_en_drop", 64'(bank_wr_en), 64'(0));
        end
        step();
        in_vld = 1'b0; in_commit = 1'b0;
    endtask

    task automatic wait_start(input int eb, input int en);
        start_t s;
        int t = 0;
        while (start_q.size() == 0 && t < 60) begin step(); t++; end
        chk("sort_start_seen", 64'(start_q.size() > 0), 64'(1));
        if (start_q.size() > 0) begin
            s = start_q.pop_front();
            chk("sort_bank", 64'(s.bank), 64'(eb));
            chk("sort_n", 64'(s.n), 64'(en));
        end
    endtask

    task automatic finish_sort(input int eb, input int en, input bit err, input bit ee);
        beat_t bt;
        step(); step();
        sort_done = 1'b1; sort_error = err;
        for (int i = 0; i < en; i++) begin
            if (pend[eb].size() > 0) begin
                bt.w = pend[eb].pop_front(); bt.last = (i == en - 1); bt.err = ee;
                exp_q.push_back(bt);
            end
        end
        step();
        sort_done = 1'b0; sort_error = 1'b0;
    endtask

    task automatic drain(input string nm);
        beat_t e, o;
        int t = 0;
        while (obs_q.size() < exp_q.size() && t < 200) begin step(); t++; end
        step(); step(); step();
        chk({nm, "_beats"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            chk({nm, "_w"}, 64'(o.w), 64'(e.w));
            chk({nm, "_last"}, 64'(o.last), 64'(e.last));
            chk({nm, "_err"}, 64'(o.err), 64'(e.err));
        end
        exp_q.delete(); obs_q.delete();
        chk({nm, "_extra_start"}, 64'(start_q.size()), 64'(0));
        chk({nm, "_all_idle"}, 64'(bank_status), 64'(0));
    endtask

    typedef struct { int nw; bit cm; bit err; int eb; int en; bit ee; } vec_t;
    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit flag;
        int t;
        tbl[0] = '{1,  1'b1, 1'b0, 1, 1,  1'b0};
        tbl[1] = '{16, 1'b0, 1'b0, 0, 16, 1'b0};
        tbl[2] = '{4,  1'b1, 1'b1, 1, 4,  1'b1};
        tbl[3] = '{2,  1'b1, 1'b0, 0, 2,  1'b0};
        tbl[4] = '{16, 1'b1, 1'b1, 1, 16, 1'b1};
        tbl[5] = '{7,  1'b1, 1'b0, 0, 7,  1'b0};

        // Reset state
        step(); step(); step();
        chk("rst_in_rdy", 64'(in_rdy), 64'(1));
        chk("rst_out_vld", 64'(out_vld), 64'(0));
        chk("rst_out_w", 64'(out_w), 64'(0));
        chk("rst_sort_start", 64'(sort_start), 64'(0));
        chk("rst_sort_n", 64'(sort_n), 64'(0));
        chk("rst_status", 64'(bank_status), 64'(0));
        chk("rst_rd_en", 64'(bank_rd_en), 64'(0));
        rst = 1'b0;
        step();

        // Basic set 5,1,3 on bank0
        enq(32'd5, 1'b0, 1'b1, 0, 0);
        chk("t1_loading", 64'(bank_status[2:0]), 64'(S_LOAD));
        enq(32'd1, 1'b0, 1'b1, 0, 1);
        enq(32'd3, 1'b1, 1'b1, 0, 2);
        chk("t1_ready", 64'(bank_status[2:0]), 64'(S_READY));
        step();
        chk("t1_sorting", 64'(bank_status[2:0]), 64'(S_SORTING));
        wait_start(0, 3);
        finish_sort(0, 3, 1'b0, 1'b0);
        chk("t1_sorted", 64'(bank_status[2:0]), 64'(S_SORTED));
        drain("t1");

        // Table of sets, alternating banks, including auto-commit and error sets
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < tbl[k].nw; i++)
                enq($urandom, tbl[k].cm && (i == tbl[k].nw - 1), 1'b1, tbl[k].eb, i);
            wait_start(tbl[k].eb, tbl[k].en);
            finish_sort(tbl[k].eb, tbl[k].en, tbl[k].err, tbl[k].ee);
            drain($sformatf("vec%0d", k));
        end

        // 17 words without commit: auto-commit at 16, 17th opens bank0
        for (int i = 0; i < 16; i++) enq($urandom, 1'b0, 1'b1, 1, i);
        chk("t2_ready", 64'(bank_status[5:3]), 64'(S_READY));
        enq($urandom, 1'b0, 1'b1, 0, 0);
        wait_start(1, 16);
        finish_sort(1, 16, 1'b0, 1'b0);
        chk("t2_b0_loading", 64'(bank_status[2:0]), 64'(S_LOAD));
        enq($urandom, 1'b1, 1'b1, 0, 1);
        wait_start(0, 2);
        finish_sort(0, 2, 1'b0, 1'b0);
        drain("t2");

        // Bank1 sorting, bank0 ready: enqueue blocked, bank0 waits for engine
        for (int i = 0; i < 3; i++) enq($urandom, i == 2, 1'b1, 1, i);
        wait_start(1, 3);
        enq($urandom, 1'b0, 1'b1, 0, 0);
        enq($urandom, 1'b1, 1'b1, 0, 1);
        enq(32'hDEAD_BEEF, 1'b1, 1'b0, 0, 0);
        chk("t3_status", 64'(bank_status), 64'({S_SORTING, S_READY}));
        step(); step(); step(); step();
        chk("t3_no_start", 64'(start_q.size()), 64'(0));
        finish_sort(1, 3, 1'b0, 1'b0);
        flag = 1'b0; t = 0;
        while (bank_status[5:3] != S_IDLE && t < 40) begin
            if (in_rdy) flag = 1'b1;
            step(); t++;
        end
        chk("t3_rdy_early", 64'(flag), 64'(0));
        chk("t3_rdy_after_unload", 64'(in_rdy), 64'(1));
        wait_start(0, 2);
        finish_sort(0, 2, 1'b0, 1'b0);
        drain("t3");

        // Spurious completion while nothing is sorting
        sort_done = 1'b1; sort_error = 1'b1;
        step();
        sort_done = 1'b0; sort_error = 1'b0;
        step();
        chk("t6_status", 64'(bank_status), 64'(0));
        enq($urandom, 1'b0, 1'b1, 1, 0);
        enq($urandom, 1'b1, 1'b1, 1, 1);
        wait_start(1, 2);
        finish_sort(1, 2, 1'b0, 1'b0);
        drain("t6");

        // Reset in the middle of an unload
        for (int i = 0; i < 4; i++) enq($urandom, i == 3, 1'b1, 0, i);
        wait_start(0, 4);
        finish_sort(0, 4, 1'b0, 1'b0);
        t = 0;
        while (obs_q.size() < 2 && t < 40) begin step(); t++; end
        rst = 1'b1;
        step();
        chk("t5_out_vld", 64'(out_vld), 64'(0));
        chk("t5_status", 64'(bank_status), 64'(0));
        chk("t5_in_rdy", 64'(in_rdy), 64'(1));
        chk("t5_truncated", 64'(obs_q.size() >= 2 && obs_q.size() < 4), 64'(1));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            chk("t5_w", 64'(obs_q.pop_front().w), 64'(exp_q.pop_front().w));
        exp_q.delete(); obs_q.delete(); start_q.delete();
        pend[0].delete(); pend[1].delete();
        rst = 1'b0;
        step(); step(); step();
        chk("t5_quiet", 64'(obs_q.size()), 64'(0));

        // Pointers restart at bank0 after reset
        enq(32'h1234_5678, 1'b1, 1'b1, 0, 0);
        wait_start(0, 1);
        finish_sort(0, 1, 1'b0, 1'b0);
        drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
